uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `N_REQ` byte producers. Each requester offers bytes over a valid/ready handshake. The arbiter grants one byte at a time, drives the transmitter's `data_in`/`send` pair, and tracks the transmitter's `busy` flag until the frame completes. A packet lock keeps a multi-byte message from one requester contiguous on the serial line. It sits directly in front of `uart_tx`, between the producers and the transmitter.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx from N_REQ byte producers.
// A packet lock keeps a multi-byte message from one requester contiguous.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 8,
  localparam int ID_W        = $clog2(N_REQ),
  localparam int CNT_W       = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             err_r, err_nxt_s;
  logic [7:0]       tx_data_r;
  logic [ID_W-1:0]  grant_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic             locked_r;
  logic [ID_W-1:0]  lock_id_r;
  logic             win_found_s;
  logic [ID_W-1:0]  win_id_s;
  logic [ID_W-1:0]  cand_s;
  logic [ID_W:0]    sum_s;
  logic             accept_s;
  logic             clr_lock_s;
  logic [ID_W-1:0]  rr_nxt_s;

  // Winner search: the lock owner alone, or the first valid at/after rr_ptr.
  // Scanning offsets downward lets the smallest offset overwrite the rest.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    cand_s      = {ID_W{1'b0}};
    sum_s       = {(ID_W+1){1'b0}};
    if (locked_r) begin
      win_found_s = req_valid[lock_id_r];
      win_id_s    = lock_id_r;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        sum_s       = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
        sum_s       = (sum_s >= (ID_W+1)'(N_REQ)) ? (sum_s - (ID_W+1)'(N_REQ)) : sum_s;
        cand_s      = sum_s[ID_W-1:0];
        win_found_s = win_found_s | req_valid[cand_s];
        win_id_s    = req_valid[cand_s] ? cand_s : win_id_s;
      end
    end
  end

  assign accept_s = (state_r == IDLE) && win_found_s;
  assign rr_nxt_s = (win_id_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (win_id_s + ID_W'(1'b1));

  // Mealy acceptance strobe towards the winning requester
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    if (accept_s) begin
      req_ready[win_id_s] = 1'b1;
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // Next-state, busy-timeout counter and error pulse
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = 1'b0;
    clr_lock_s  = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = accept_s ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        state_nxt_s = WAIT_BUSY;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      WAIT_BUSY: begin
        // busy rising on the final count still wins over the timeout
        if (tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else if (cnt_r == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_nxt_s = IDLE;
          err_nxt_s   = 1'b1;
          clr_lock_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
        end
      end
      WAIT_DONE: begin
        state_nxt_s = tx_busy ? WAIT_DONE : IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, timeout counter and error pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Captured byte, grant and round-robin / lock bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_r <= 8'h00;
      grant_r   <= {ID_W{1'b0}};
      rr_ptr_r  <= {ID_W{1'b0}};
      locked_r  <= 1'b0;
      lock_id_r <= {ID_W{1'b0}};
    end else if (accept_s) begin
      tx_data_r <= req_data[{win_id_s, 3'b000} +: 8];
      grant_r   <= win_id_s;
      rr_ptr_r  <= rr_nxt_s;
      locked_r  <= ~req_last[win_id_s];
      lock_id_r <= win_id_s;
    end else if (clr_lock_s) begin
      locked_r  <= 1'b0;
    end
  end

  assign tx_data     = tx_data_r;
  assign grant_id    = grant_r;
  assign tx_send     = (state_r == LAUNCH);
  assign active      = (state_r != IDLE);
  assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: producer queues and a uart_tx busy model
// drive the DUT; a monitor pops expected grants on each tx_send.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BT = 8;

  typedef struct {
    logic [7:0] data;
    int         id;
    int         cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_timeout;

  exp_t       exp_q[$];
  logic [8:0] pq[N][$];
  int         acc_log[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  int         m_ptr = 0;
  bit         m_locked = 1'b0;
  int         m_lock = 0;
  int         exp_err = -1;
  bit         gate = 1'b0;
  bit         stuck_rand = 1'b0;
  int         stuck_budget = 0;
  int         rise = 0;
  int         high = 0;
  int         dur = 0;
  int         n_err_seen = 0;
  logic [7:0] hold_data = 8'h00;
  int         hold_id = 0;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_send(tx_send), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Producers plus the reference arbitration model (spec rules on plain ints)
  initial begin
    int  w, a;
    bit  found;
    logic [N-1:0] er;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() > 0 && (!gate || $urandom_range(3) != 0)) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = pq[i][0][7:0];
          req_last[i]        = pq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
        end
      end
      #1;
      if (!rst) begin
        m_ptr    = 0;
        m_locked = 1'b0;
        check("ready_in_reset", req_ready, 0);
      end else begin
        if (cyc == exp_err) m_locked = 1'b0;
        found = 1'b0;
        w     = 0;
        if (m_locked) begin
          found = req_valid[m_lock];
          w     = m_lock;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
              found = 1'b1;
              w     = (m_ptr + k) % N;
            end
          end
        end
        er = (!active && found) ? ({{(N-1){1'b0}}, 1'b1} << w) : '0;
        check("req_ready", req_ready, er);
        if ((req_ready & req_valid) != '0) begin
          a = 0;
          for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) a = i;
          if (!found) w = a;
          exp_q.push_back('{data: pq[w][0][7:0], id: w, cyc: cyc});
          acc_log.push_back(w);
          m_ptr    = (w + 1) % N;
          m_locked = !pq[w][0][8];
          m_lock   = w;
          void'(pq[a].pop_front());
        end
      end
    end
  end

  // Monitor and uart_tx busy model
  initial begin
    exp_t e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        tx_busy = 1'b0;
        rise = 0;
        high = 0;
        exp_q.delete();
        exp_err   = -1;
        hold_data = 8'h00;
        hold_id   = 0;
      end else begin
        check("err_timeout", err_timeout, cyc == exp_err);
        if (err_timeout) n_err_seen++;
        if (exp_q.size() == 0) begin
          check("tx_data_hold", tx_data, hold_data);
          check("grant_id_hold", grant_id, hold_id);
        end
        if (tx_send) begin
          check("busy_before_send", tx_busy, 0);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_without_accept: tx_send=1 with no accepted byte (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e.data);
            check("grant_id", grant_id, e.id);
            check("send_latency", cyc - e.cyc, 1);
            hold_data = e.data;
            hold_id   = e.id;
          end
          if (stuck_budget > 0 || (stuck_rand && $urandom_range(7) == 0)) begin
            if (stuck_budget > 0) stuck_budget--;
            exp_err = cyc + 1 + BT;
          end else begin
            rise = $urandom_range(1, 4);
            dur  = $urandom_range(2, 6);
          end
        end else if (rise > 0) begin
          rise--;
          if (rise == 0) begin
            tx_busy = 1'b1;
            high    = dur;
          end
        end else if (high > 0) begin
          high--;
          if (high == 0) tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_tx_send", tx_send, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) pq[i].delete();
    acc_log.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    bit done = 1'b0;
    bit empty;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      empty = 1'b1;
      for (int r = 0; r < N; r++) if (pq[r].size() != 0) empty = 1'b0;
      done = empty && exp_q.size() == 0 && !active && !tx_busy && rise == 0;
    end
    n_vec++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: not idle after %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_accepts(input string nm, input int n, input int budget);
    int i = 0;
    while (acc_log.size() < n && i < budget) begin
      @(negedge clk);
      #2;
      i++;
    end
    check({nm, "_accepts"}, acc_log.size() >= n, 1);
  endtask

  task automatic check_log(input string nm, input int e[$]);
    check({nm, "_count"}, acc_log.size(), e.size());
    for (int i = 0; i < e.size() && i < acc_log.size(); i++) check(nm, acc_log[i], e[i]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eo[$];
    int total;
    int r, len;
    rst = 1'b1;
    #2;
    do_reset();

    // single byte from requester 2
    pq[2].push_back({1'b1, 8'hA5});
    wait_drain("single", 200);
    eo = '{2};
    check_log("single_order", eo);
    check("single_idle", active, 0);

    // round-robin over four requesters
    do_reset();
    for (int i = 0; i < N; i++) pq[i].push_back({1'b1, 8'(8'h10 + i)});
    for (int i = 0; i < 2; i++) pq[i].push_back({1'b1, 8'(8'h10 + i)});
    wait_drain("rr", 400);
    eo = '{0, 1, 2, 3, 0, 1};
    check_log("rr_order", eo);

    // packet lock holds requester 1 against requester 0
    do_reset();
    pq[1].push_back({1'b0, 8'h41});
    pq[1].push_back({1'b0, 8'h42});
    pq[1].push_back({1'b1, 8'h43});
    wait_accepts("lock", 1, 100);
    pq[0].push_back({1'b1, 8'h50});
    wait_drain("lock", 400);
    eo = '{1, 1, 1, 0};
    check_log("lock_order", eo);

    // busy timeout clears the lock
    do_reset();
    n_err_seen   = 0;
    stuck_budget = 1;
    pq[0].push_back({1'b0, 8'h61});
    pq[0].push_back({1'b1, 8'h62});
    pq[1].push_back({1'b1, 8'h71});
    wait_drain("timeout", 400);
    eo = '{0, 1, 0};
    check_log("timeout_order", eo);
    check("timeout_pulses", n_err_seen, 1);

    // reset during WAIT_DONE, then 0xC3 (req 0) before 0x3C (req 3)
    do_reset();
    pq[2].push_back({1'b1, 8'h77});
    for (int i = 0; i < 100 && !tx_busy; i++) begin
      @(negedge clk);
      #2;
    end
    check("midframe_busy_seen", tx_busy, 1);
    @(posedge clk);
    #2;
    do_reset();
    pq[3].push_back({1'b1, 8'h3C});
    pq[0].push_back({1'b1, 8'hC3});
    wait_drain("postreset", 300);
    eo = '{0, 3};
    check_log("postreset_order", eo);

    // randomized packets with gapped valids and occasional stuck busy
    do_reset();
    gate       = 1'b1;
    stuck_rand = 1'b1;
    total      = 0;
    for (int p = 0; p < 40; p++) begin
      r   = $urandom_range(N - 1);
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        pq[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        total++;
      end
    end
    wait_drain("random", 20000);
    check("random_byte_count", acc_log.size(), total);
    gate       = 1'b0;
    stuck_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
